// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state codes and parity sense.
package uart_tx_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic PAR_ODD = 1'b1;
endpackage

// File: rtl/baud_gen.sv
// Oversampled baud tick: one-cycle pulse every CLK_FREQ/(BAUD_RATE*OVERSAMPLING) clocks.
module baud_gen #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLING = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLING);
  localparam int DIV = (RAW < 1) ? 1 : RAW;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_ser.sv
// Frame serialiser: FSM, tick and bit counters, shift register, registered line.
import uart_tx_pkg::*;

module uart_tx_ser #(
  parameter int WORD_WIDTH   = 8,
  parameter int OVERSAMPLING = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic                  par_en,
  output logic                  done,
  output logic                  active,
  output logic                  dout
);
  localparam int TW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(WORD_WIDTH);

  logic [2:0]            state;
  logic [TW-1:0]         tcnt;
  logic [BW-1:0]         bcnt;
  logic [WORD_WIDTH-1:0] shreg;
  logic                  par_en_q;
  logic                  par_bit;
  logic                  dout_q;
  logic                  last;

  assign last   = tick & (tcnt == TW'(OVERSAMPLING - 1));
  assign active = (state != ST_IDLE);
  assign done   = (state == ST_STOP) & last;
  assign dout   = dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tcnt     <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      dout_q   <= 1'b1;
    end else if (load) begin
      // load wins over the STOP-end tick so frames chain with no gap
      shreg    <= data;
      par_en_q <= par_en;
      par_bit  <= (^data) ^ PAR_ODD;
      state    <= ST_START;
      tcnt     <= '0;
      bcnt     <= '0;
      dout_q   <= 1'b0;
    end else if (last) begin
      tcnt <= '0;
      case (state)
        ST_START: begin
          state  <= ST_DATA;
          dout_q <= shreg[0];
        end
        ST_DATA: begin
          if (bcnt == BW'(WORD_WIDTH - 1)) begin
            bcnt   <= '0;
            state  <= par_en_q ? ST_PARITY : ST_STOP;
            dout_q <= par_en_q ? par_bit : 1'b1;
          end else begin
            bcnt   <= bcnt + 1'b1;
            shreg  <= shreg >> 1;
            dout_q <= shreg[1];
          end
        end
        ST_PARITY: begin
          state  <= ST_STOP;
          dout_q <= 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          dout_q <= 1'b1;
        end
      endcase
    end else if (tick && active) begin
      tcnt <= tcnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter top: one-entry holding buffer with valid/ready write port.
import uart_tx_pkg::*;

module uart_tx #(
  parameter int WORD_WIDTH   = 8,
  parameter int OVERSAMPLING = 16,
  parameter int BAUD_RATE    = 115200,
  parameter int CLK_FREQ     = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  parity_cfg,
  output logic                  dout,
  output logic                  busy
);
  logic                  tick;
  logic                  load;
  logic                  done;
  logic                  active;
  logic                  hold_full;
  logic [WORD_WIDTH-1:0] hold_data;

  baud_gen #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .OVERSAMPLING (OVERSAMPLING)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  uart_tx_ser #(
    .WORD_WIDTH   (WORD_WIDTH),
    .OVERSAMPLING (OVERSAMPLING)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .load   (load),
    .data   (hold_data),
    .par_en (parity_cfg),
    .done   (done),
    .active (active),
    .dout   (dout)
  );

  // ready is the buffer flag itself: no path from wr_valid
  assign wr_ready = ~hold_full;
  assign load     = hold_full & (~active | done);
  assign busy     = active | hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (wr_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= wr_data;
    end
  end
endmodule
